// File: rtl/secded_if.sv
// Handshake and result bus between a codeword source, the SECDED decoder and its consumer.
interface secded_if;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] code_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] data_out;
  logic [7:0]  syndrome;
  logic        err_ce;
  logic        err_ue;
  logic [6:0]  err_pos;

  // decoder side
  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, syndrome, err_ce, err_ue, err_pos
  );

  // source/sink side
  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, syndrome, err_ce, err_ue, err_pos
  );
endinterface

// File: rtl/secded_decoder.sv
// SECDED (72,64) check matrix plus a pipelined receive-side decoder with saturating error counters.
package SECDED_ECC_pkg;
  // Data columns: all weight-3 bytes in ascending order, then the first eight weight-5 bytes.
  // Odd-weight, distinct, and never weight 1, so every double error gives an even nonzero
  // syndrome that matches no column.
  function automatic logic [63:0][7:0] gen_cols();
    logic [63:0][7:0] c;
    logic [7:0]       b;
    int               n;
    c = '0;
    n = 0;
    for (int w = 3; w <= 5; w += 2) begin
      for (int v = 0; v < 256; v++) begin
        b = 8'(v);
        if ($countones(b) == w && n < 64) begin
          c[n[5:0]] = b;
          n++;
        end
      end
    end
    return c;
  endfunction

  localparam logic [63:0][7:0] H_COLS = gen_cols();

  // Check bits of a 64-bit data word.
  function automatic logic [7:0] mega_xor(input logic [63:0] d);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 64; i++)
      if (d[i[5:0]]) s ^= H_COLS[i[5:0]];
    return s;
  endfunction

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  syn;
    logic        ce;
    logic        ue;
    logic [6:0]  pos;
  } dec_rsp_t;
endpackage

module secded_decoder
  import SECDED_ECC_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter bit PIPE_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  secded_if.slave          bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ce_count,
  output logic [CNT_W-1:0] ue_count
);

  logic        s1_vld_q, s1_vld_d;
  logic [71:0] s1_code_q, s1_code_d;
  logic [7:0]  s1_syn_q, s1_syn_d;
  logic        s1_adv, out_adv, out_fire;
  dec_rsp_t    cls;

  assign s1_adv      = !s1_vld_q | out_adv;
  assign bus.in_ready = s1_adv;

  // Stage 1: capture the codeword and its syndrome on accept, hold otherwise.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_code_d = s1_code_q;
    s1_syn_d  = s1_syn_q;
    if (s1_adv) begin
      s1_vld_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_code_d = bus.code_in;
        s1_syn_d  = mega_xor(bus.code_in[63:0]) ^ bus.code_in[71:64];
      end
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_code_q <= '0;
      s1_syn_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_code_q <= s1_code_d;
      s1_syn_q  <= s1_syn_d;
    end
  end

  // Classify the stage-1 syndrome: clean, single (data or check column), or uncorrectable.
  always_comb begin
    cls.data = s1_code_q[63:0];
    cls.syn  = s1_syn_q;
    cls.ce   = 1'b0;
    cls.ue   = 1'b0;
    cls.pos  = '0;
    if (s1_syn_q != 8'h00) begin
      for (int k = 0; k < 64; k++) begin
        if (s1_syn_q == H_COLS[k[5:0]]) begin
          cls.ce   = 1'b1;
          cls.pos  = 7'(k);
          cls.data = s1_code_q[63:0] ^ (64'd1 << k);
        end
      end
      for (int j = 0; j < 8; j++) begin
        if (s1_syn_q == (8'd1 << j)) begin
          cls.ce  = 1'b1;
          cls.pos = 7'(64 + j);
        end
      end
      cls.ue = !cls.ce;
    end
  end

  if (PIPE_OUT) begin : g_reg
    logic     o_vld_q, o_vld_d;
    dec_rsp_t o_q, o_d;

    assign out_adv = !o_vld_q | bus.out_ready;

    // Output stage: take the classified word when empty or draining, hold while stalled.
    always_comb begin
      o_vld_d = o_vld_q;
      o_d     = o_q;
      if (out_adv) begin
        o_vld_d = s1_vld_q;
        if (s1_vld_q) o_d = cls;
      end
    end

    // Output stage registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        o_vld_q <= 1'b0;
        o_q     <= '0;
      end else begin
        o_vld_q <= o_vld_d;
        o_q     <= o_d;
      end
    end

    assign bus.out_valid = o_vld_q;
    assign bus.data_out  = o_q.data;
    assign bus.syndrome  = o_q.syn;
    assign bus.err_ce    = o_q.ce;
    assign bus.err_ue    = o_q.ue;
    assign bus.err_pos   = o_q.pos;
  end else begin : g_comb
    // Stage 1 drives the outputs directly; it frees up when downstream takes the word.
    assign out_adv       = bus.out_ready;
    assign bus.out_valid = s1_vld_q;
    assign bus.data_out  = cls.data;
    assign bus.syndrome  = cls.syn;
    assign bus.err_ce    = cls.ce;
    assign bus.err_ue    = cls.ue;
    assign bus.err_pos   = cls.pos;
  end

  logic [CNT_W-1:0] ce_q, ce_d, ue_q, ue_d;

  assign out_fire = bus.out_valid & bus.out_ready;

  // Counters bump once per output transfer, saturate, and clear takes priority.
  always_comb begin
    ce_d = ce_q;
    ue_d = ue_q;
    if (cnt_clr) begin
      ce_d = '0;
      ue_d = '0;
    end else if (out_fire) begin
      if (bus.err_ce && ce_q != '1) ce_d = ce_q + 1'b1;
      if (bus.err_ue && ue_q != '1) ue_d = ue_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_q <= '0;
      ue_q <= '0;
    end else begin
      ce_q <= ce_d;
      ue_q <= ue_d;
    end
  end

  assign ce_count = ce_q;
  assign ue_count = ue_q;

endmodule

// File: tb/tb_secded_decoder.sv
// Scoreboard bench for secded_decoder (CNT_W=4, registered output stage).
module tb_secded_decoder;
  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  s;
    logic        ce;
    logic        ue;
    logic [6:0]  pos;
  } exp_t;

  // Data-bit columns of the check matrix, written out by hand.
  localparam logic [7:0] COLS [64] = '{
    8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
    8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
    8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
    8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62,
    8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89, 8'h8A,
    8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2, 8'hA4,
    8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
    8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57
  };
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;

  logic       clk, rst, cnt_clr;
  logic [3:0] ce_count, ue_count;
  int         or_mode;   // 0: out_ready=1, 1: 1,0,0 pattern, 2: out_ready=0
  int         orc;
  int         checks, errors;
  exp_t       sb[$];

  secded_if ifc();

  secded_decoder #(.CNT_W(4), .PIPE_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .cnt_clr(cnt_clr),
    .ce_count(ce_count), .ue_count(ue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] col(input int k);
    return (k < 64) ? COLS[k] : (8'd1 << (k - 64));
  endfunction

  function automatic logic [7:0] syn_of(input logic [71:0] c);
    logic [7:0] s;
    s = '0;
    for (int k = 0; k < 72; k++) if (c[k]) s ^= col(k);
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Build a codeword for d with the given bits flipped, and its expected decode.
  task automatic mk(input logic [63:0] d, input logic [71:0] flips,
                    output logic [71:0] code, output exp_t e);
    int n;
    code  = {syn_of({8'h00, d}), d} ^ flips;
    n     = $countones(flips);
    e.s   = syn_of(code);
    e.ce  = (n == 1);
    e.ue  = (n >= 2);
    e.d   = (n >= 2) ? code[63:0] : d;
    e.pos = '0;
    if (n == 1) for (int k = 0; k < 72; k++) if (flips[k]) e.pos = 7'(k);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [71:0] code, input exp_t e);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    ifc.in_valid = 1'b1;
    ifc.code_in  = code;
    while (!acc && n < 200) begin
      #3;
      acc = ifc.in_ready;
      if (acc) sb.push_back(e);
      @(negedge clk);
      n++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected in_ready within 200 cycles");
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic sendf(input logic [63:0] d, input logic [71:0] flips);
    logic [71:0] code;
    exp_t        e;
    mk(d, flips, code, e);
    send(code, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ifc.in_valid = 1'b0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Downstream ready driver.
  initial begin
    orc = 0;
    ifc.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      orc++;
      case (or_mode)
        1:       ifc.out_ready = (orc % 3 == 0);
        2:       ifc.out_ready = 1'b0;
        default: ifc.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pop and compare on each output transfer; check hold while stalled.
  initial begin
    exp_t act, held, e;
    bit   stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst) stall = 1'b0;
      else begin
        act = {ifc.data_out, ifc.syndrome, ifc.err_ce, ifc.err_ue, ifc.err_pos};
        if (stall) begin
          checks++;
          if (!ifc.out_valid || act !== held) begin
            errors++;
            $display("FAIL stall_hold: got v=%b %h expected v=1 %h", ifc.out_valid, act, held);
          end
        end
        if (ifc.out_valid && ifc.out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h expected no output", act);
          end else begin
            e = sb.pop_front();
            if (act !== e) begin
              errors++;
              $display("FAIL result: got d=%h s=%h ce=%b ue=%b pos=%0d expected d=%h s=%h ce=%b ue=%b pos=%0d",
                       act.d, act.s, act.ce, act.ue, act.pos, e.d, e.s, e.ce, e.ue, e.pos);
            end
          end
        end
        stall = ifc.out_valid && !ifc.out_ready;
        held  = act;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b, n;
    checks = 0; errors = 0; or_mode = 0;
    rst = 1'b1; cnt_clr = 1'b0;
    ifc.in_valid = 1'b0; ifc.code_in = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", 64'(ifc.out_valid), 0);
    chk("rst_data_out", ifc.data_out, 0);
    chk("rst_syndrome", 64'(ifc.syndrome), 0);
    chk("rst_err", 64'({ifc.err_ce, ifc.err_ue, ifc.err_pos}), 0);
    chk("rst_counts", 64'({ce_count, ue_count}), 0);
    @(negedge clk);
    rst = 1'b0;
    #3 chk("in_ready_after_rst", 64'(ifc.in_ready), 1);
    @(negedge clk);

    // clean word and two-cycle latency
    sendf(D0, '0);
    #3 chk("latency_n1", 64'(ifc.out_valid), 0);
    @(negedge clk);
    #3 chk("latency_n2", 64'(ifc.out_valid), 1);
    @(negedge clk);
    drain();

    sendf(D0, 72'd1 << 37);
    drain();
    #3 chk("ce_count_one", 64'(ce_count), 1);
    @(negedge clk);

    sendf(D0, 72'd1 << 69);
    drain();

    sendf(D0, (72'd1 << 3) | (72'd1 << 50));
    drain();
    #3 chk("ue_count_one", 64'(ue_count), 1);
    chk("ce_count_two", 64'(ce_count), 2);
    @(negedge clk);

    // every single-bit position, back to back; counter saturates
    for (int k = 0; k < 72; k++) sendf({D0[31:0], D0[63:32]}, 72'd1 << k);
    drain();
    #3 chk("ce_count_sat", 64'(ce_count), 15);
    @(negedge clk);

    // random double errors
    for (int i = 0; i < 100; i++) begin
      a = $urandom_range(0, 71);
      b = $urandom_range(0, 71);
      while (b == a) b = $urandom_range(0, 71);
      sendf({$urandom, $urandom}, (72'd1 << a) | (72'd1 << b));
    end
    drain();
    #3 chk("ue_count_sat", 64'(ue_count), 15);
    @(negedge clk);

    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #3 chk("clr_counts", 64'({ce_count, ue_count}), 0);
    @(negedge clk);
    sendf(D0, 72'd1 << 10);
    drain();
    #3 chk("ce_after_clr", 64'(ce_count), 1);
    @(negedge clk);

    // clear in the same cycle as a CE transfer
    or_mode = 2;
    sendf(D0, 72'd1 << 20);
    n = 0;
    while (n < 20) begin
      #3;
      if (ifc.out_valid) break;
      @(negedge clk);
      n++;
    end
    chk("held_word_valid", 64'(ifc.out_valid), 1);
    @(negedge clk);
    or_mode = 0;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #3 chk("clr_wins", 64'(ce_count), 0);
    @(negedge clk);
    drain();

    // backpressure stream: 3 CE, 1 UE
    or_mode = 1;
    for (int i = 0; i < 8; i++) begin
      case (i)
        1:       sendf(D0 + 64'(i), 72'd1 << 5);
        3:       sendf(D0 + 64'(i), 72'd1 << 64);
        4:       sendf(D0 + 64'(i), (72'd1 << 1) | (72'd1 << 2));
        6:       sendf(D0 + 64'(i), 72'd1 << 63);
        default: sendf(D0 + 64'(i), '0);
      endcase
    end
    drain();
    #3 chk("bp_ce_count", 64'(ce_count), 3);
    chk("bp_ue_count", 64'(ue_count), 1);
    @(negedge clk);

    // reset with two words in flight
    or_mode = 2;
    @(negedge clk);
    sendf(D0, 72'd1 << 7);
    sendf(D0, 72'd1 << 8);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #3 chk("midrst_out_valid", 64'(ifc.out_valid), 0);
    chk("midrst_counts", 64'({ce_count, ue_count}), 0);
    chk("midrst_in_ready", 64'(ifc.in_ready), 1);
    @(negedge clk);
    or_mode = 0;
    repeat (6) @(negedge clk);
    sendf(D0, '0);
    drain();
    #3 chk("post_rst_ce", 64'(ce_count), 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/secded_decoder.md
Name: secded_decoder

Overview:
Pipelined receive-side SECDED checker for 72-bit codewords laid out as {check[7:0], data[63:0]}, with check bits in [71:64]. It recomputes check bits with mega_xor from SECDED_ECC_pkg, corrects any single-bit error and flags double or uncorrectable errors. It also keeps saturating error counters for status/CSR readout. It sits at the read side of memories and links fed by SECDED_Encoder.

Parameters:
CNT_W, 16, width of the corrected-error and uncorrectable-error counters
PIPE_OUT, 1, 1 = registered output stage (latency 2); 0 = output taken combinationally from stage 1 (latency 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  codeword valid
in_ready  out  1  decoder can accept a codeword
code_in  in  72  received codeword
out_valid  out  1  decoded result valid
out_ready  in  1  downstream accepts the result
data_out  out  64  corrected data
syndrome  out  8  raw syndrome of the word presented on data_out
err_ce  out  1  single-bit error corrected; includes check-bit-only errors
err_ue  out  1  uncorrectable error; data_out = uncorrected data bits
err_pos  out  7  flipped bit index 0..71, valid when err_ce=1, else 0
cnt_clr  in  1  synchronous clear of both counters
ce_count  out  CNT_W  corrected-error count, saturating
ue_count  out  CNT_W  uncorrectable-error count, saturating

Behaviour:
- Reset (rst=1 on a clk edge): all pipeline valids = 0; data_out, syndrome, err_* = 0; counters = 0. A word in flight is discarded.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - in_ready = !stage_full | (downstream stage advancing); full-throughput pipeline, 1 word/cycle with no bubbles.
  - A stalled stage holds its contents and outputs stable while out_valid=1 & out_ready=0.
  - No combinational path from in_valid to out_valid.
- Stage 1, register on accept: code_in, syndrome S = mega_xor(code_in[63:0]) ^ code_in[71:64].
- Column set:
  - Data bit i (0..63): C_i = mega_xor(64'b1<<i).
  - Check bit j (0..7), codeword bit 64+j: C = 8'b1<<j.
- Classification:
  - S==0: clean; err_ce=0, err_ue=0.
  - S equals exactly one column k: err_ce=1, err_pos=k. If k<64, data_out = data ^ (1<<k); otherwise data passes unchanged.
  - Else: err_ue=1, data unchanged, err_pos=0.
  - err_ce and err_ue are never both 1.
- Latency: in transfer at cycle N -> out_valid at N+2 (PIPE_OUT=1) or N+1 (PIPE_OUT=0), absent backpressure.
- Counters:
  - Increment once per output transfer with err_ce (ce_count) or err_ue (ue_count).
  - Saturate at 2^CNT_W-1, no wrap.
  - cnt_clr wins over a same-cycle increment; the counter reads 0 next cycle.
  - Counters are not affected by stalls; a held word is never double-counted.
- rst asserted mid-stream: all in-flight words are lost. in_ready = 1 on the first cycle after reset deasserts.

Test Plan:
- Clean word: D=64'h0123_4567_89AB_CDEF, code={mega_xor(D),D} -> data_out=D, syndrome=0, err_ce=0, err_ue=0, 2 cycles after accept.
- Single data-bit error: same code with bit 37 flipped -> data_out=D, err_ce=1, err_pos=37, syndrome=mega_xor(1<<37), ce_count=1. Sweep all 72 bit positions and check err_pos for each.
- Single check-bit error: bit 69 flipped -> data_out=D, err_ce=1, err_pos=69, syndrome=8'h20.
- Double error: bits 3 and 50 flipped -> err_ue=1, err_ce=0, data_out = D with bits 3 and 50 still flipped, ue_count=1. Sweep 100 random bit pairs; err_ce must never assert.
- Backpressure: stream 8 words while out_ready toggles 1,0,0,1... -> all 8 words out in order, no drops or duplicates, outputs stable during stall, ce_count equals the number of injected single-bit errors.
- Counters and reset: CNT_W=4, inject 20 single-bit errors -> ce_count=15 (saturated). Assert cnt_clr in the same cycle as another CE transfer -> 0. Assert rst with 2 words in flight -> out_valid=0 and counters 0 next cycle; the lost words never appear at the output.
